mem32_req_ctrl: RTL
===================

# mem32_req_ctrl

Request controller that sits directly upstream of the 32x32 memory block and is its only driver of `wr_en`, `rd_en`, `addr` and `data_in`. It accepts read/write requests on a valid/ready port and checks the memory's `full`/`empty` flags before issuing each request. It returns one response per request, either read data or a write acknowledgement with an error flag, through a 2-entry response FIFO. Only one memory operation is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 5, memory address width
- `DATA_W`, 32, data width
- `RSP_DEPTH`, 2, response FIFO depth (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller accepts the request this cycle
- `req_wr`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  target word
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  response available at FIFO head
- `rsp_ready`  in  1  consumer takes the head response
- `rsp_wr`  out  1  response belongs to a write
- `rsp_err`  out  1  request rejected (write while full / read while empty)
- `rsp_addr`  out  ADDR_W  address of the request
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and for errors
- `mem_wr_en`, `mem_rd_en`  out  1  to memory `wr_en`/`rd_en`
- `mem_addr`  out  ADDR_W  to memory `addr`
- `mem_wdata`  out  DATA_W  to memory `data_in`
- `mem_rdata`  in  DATA_W  from memory `data_out`
- `mem_full`, `mem_empty`  in  1  memory flags
- `err_cnt`  out  8  saturating count of error responses

## Operation
FSM states: IDLE, EXEC, RDWAIT.
- **IDLE**
  - `req_ready` = (FIFO occupancy < RSP_DEPTH).
  - On `req_valid && req_ready`: latch `req_wr`, `req_addr`, `req_wdata`; go to EXEC.
- **EXEC, write**
  - If `!mem_full`: `mem_wr_en`=1 this cycle; push {wr=1, err=0, rdata=0}.
  - Else: no memory access; push {wr=1, err=1}.
  - Next state: IDLE.
- **EXEC, read**
  - If `!mem_empty`: `mem_rd_en`=1 this cycle; go to RDWAIT.
  - Else: push {wr=0, err=1, rdata=0}; go to IDLE.
- **RDWAIT**: push {wr=0, err=0, rdata=`mem_rdata`}; go to IDLE.
- **Memory-side outputs**
  - `mem_addr`/`mem_wdata` come from the latched request.
  - `mem_wr_en`/`mem_rd_en` are decoded from state; they are never both 1 and are 0 outside EXEC.
- **FIFO push/pop**
  - Push and pop in the same cycle are both honoured.
  - Accepting a request only at occupancy < RSP_DEPTH guarantees a push never overflows.
- **`err_cnt`**: increments on every error push; saturates at 255.

## Timing
- Reset values: state IDLE; FIFO empty; `req_ready`=0 while `rst_n`=0, then 1 after deassertion. All of the following are 0: `rsp_valid`, `rsp_wr`, `rsp_err`, `rsp_addr`, `rsp_rdata`, `mem_wr_en`, `mem_rd_en`, `mem_addr`, `mem_wdata`, `err_cnt`.
- Request-to-response latency: write 2 cycles, read 3 cycles, error 2 cycles.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Flag staleness: the memory flags lag a write/read by two edges. The minimum spacing of 2 cycles between EXEC states guarantees the sampled flag reflects all prior operations.
- Read data: `mem_rdata` is sampled on the edge ending RDWAIT, one cycle after `mem_rd_en`.
- Backpressure: `rsp_ready`=0 with FIFO full holds the FSM in IDLE with `req_ready`=0; no request is lost.
- Reset mid-operation: the in-flight op is dropped with no response. `mem_*_en` deassert asynchronously with `rst_n`.

## Structure
- Package `mem32_pkg`: `ADDR_W`/`DATA_W` defaults, state enum, response struct {wr, err, addr, rdata}.
- Sub-module `mem32_rsp_fifo`: parameterised sync FIFO of response structs. It has push, pop, count, empty and full outputs, async active-low reset.

## Test plan
- Write 0xDEADBEEF @5, then read @5 → write response err=0 after 2 cycles; read response rdata=0xDEADBEEF, err=0, addr=5; exactly one `mem_wr_en` and one `mem_rd_en` pulse.
- Read @0 right after reset (`mem_empty`=1) → rsp err=1, rdata=0, `mem_rd_en` never asserted, `err_cnt`=1.
- 32 writes to addresses 0..31, then a 33rd write → first 32 err=0; 33rd err=1 with no `mem_wr_en` pulse.
- Hold `rsp_ready`=0 and issue 3 writes → 2 accepted, `req_ready` stays 0. Release `rsp_ready` → responses drain in order and the third request is accepted.
- Assert `rst_n`=0 during RDWAIT → FIFO empty, `rsp_valid`=0, `mem_rd_en`=0 immediately. After release, `req_ready`=1.
- Force 300 error reads → `err_cnt` saturates at 255.

Source files
------------

// File: rtl/mem32_pkg.sv
// Shared types for the 32x32 memory request controller: FSM states and
// the response record carried through the response FIFO.
package mem32_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/mem32_req_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// memory request controller (slave).
interface mem32_req_ctrl_if #(
  parameter int ADDR_W = mem32_pkg::ADDR_W,
  parameter int DATA_W = mem32_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic              rsp_err;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_err, rsp_addr, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_err, rsp_addr, rsp_rdata
  );

endinterface

// File: rtl/mem32_rsp_fifo.sv
// Small synchronous FIFO of response records; simultaneous push and pop are
// both honoured. The caller guarantees push never arrives while full.
module mem32_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = mem32_pkg::rsp_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = pop && (r_count != '0);

  // Storage holds data only; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push)  r_wptr <= ptr_inc(r_wptr);
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/mem32_req_ctrl.sv
// Single-outstanding request controller in front of the 32x32 memory: checks
// full/empty before each access and returns one response per request.
module mem32_req_ctrl #(
  parameter int ADDR_W    = mem32_pkg::ADDR_W,
  parameter int DATA_W    = mem32_pkg::DATA_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem32_req_ctrl_if.slave    bus,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_full,
  input  logic               mem_empty,
  output logic [7:0]         err_cnt
);

  import mem32_pkg::*;

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              wr;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_err_cnt;

  logic              w_accept;
  logic              w_push;
  logic              w_push_q;
  logic              w_req_ready;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  entry_t            w_entry;
  entry_t            w_head;
  entry_t            w_rsp;

  // rst_n gates ready directly so it reads 0 throughout reset.
  assign w_req_ready = rst_n && (r_state == IDLE) && (w_count < CNT_W'(RSP_DEPTH));
  assign w_push_q    = w_push && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_push   = 1'b0;
    w_wr_en  = 1'b0;
    w_rd_en  = 1'b0;
    w_entry  = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && w_req_ready) begin
          w_accept = 1'b1;
          w_nxt    = EXEC;
        end
      end
      EXEC: begin
        w_entry.addr = r_addr;
        if (r_wr) begin
          w_entry.wr  = 1'b1;
          w_entry.err = mem_full;
          w_wr_en     = !mem_full;
          w_push      = 1'b1;
          w_nxt       = IDLE;
        end else if (!mem_empty) begin
          w_rd_en = 1'b1;
          w_nxt   = RDWAIT;
        end else begin
          w_entry.err = 1'b1;
          w_push      = 1'b1;
          w_nxt       = IDLE;
        end
      end
      RDWAIT: begin
        w_entry.addr  = r_addr;
        w_entry.rdata = mem_rdata;
        w_push        = 1'b1;
        w_nxt         = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= bus.req_wr;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push_q && w_entry.err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  mem32_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (entry_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_q),
    .push_data (w_entry),
    .pop       (bus.rsp_ready),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  // Response fields read as zero whenever nothing is queued.
  assign w_rsp         = w_empty ? '0 : w_head;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = !w_empty;
  assign bus.rsp_wr    = w_rsp.wr;
  assign bus.rsp_err   = w_rsp.err;
  assign bus.rsp_addr  = w_rsp.addr;
  assign bus.rsp_rdata = w_rsp.rdata;

  assign mem_wr_en = w_wr_en;
  assign mem_rd_en = w_rd_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err_cnt   = r_err_cnt;

endmodule
